// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the parallel nibble bus master
package comm_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } commState_t;

    function automatic int maxCyc(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/comm_parallel_master_if.sv
// rtl/comm_parallel_master_if.sv - host request/response and nibble bus signal bundle
interface comm_parallel_master_if #(
    parameter int ADDR_W = comm_pkg::DEFAULT_ADDR_W
);
    import comm_pkg::*;

    logic                reqValid;
    logic                reqReady;
    logic                reqWrite;
    logic [ADDR_W-1:0]   reqAddr;
    logic [7:0]          reqData;
    logic                rspValid;
    logic                rspReady;
    logic [7:0]          rspData;
    logic [ADDR_W-1:0]   busAddr;
    logic [NIBBLE_W-1:0] busDataOut;
    logic [NIBBLE_W-1:0] busDataIn;
    logic                busWrite;
    logic                busRead;

    modport master (
        input  reqValid, reqWrite, reqAddr, reqData, rspReady, busDataIn,
        output reqReady, rspValid, rspData, busAddr, busDataOut, busWrite, busRead
    );

    modport slave (
        output reqValid, reqWrite, reqAddr, reqData, rspReady, busDataIn,
        input  reqReady, rspValid, rspData, busAddr, busDataOut, busWrite, busRead
    );

endinterface

// File: rtl/comm_phase_timer.sv
// rtl/comm_phase_timer.sv - loadable down-counter signalling the last cycle of a bus phase
module comm_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Loading length-1 makes done high during the final cycle of the phase.
    assign done = (count == '0);

endmodule

// File: rtl/comm_parallel_master.sv
// rtl/comm_parallel_master.sv - byte request to two strobed nibble transfers on the parallel bus
module comm_parallel_master
    import comm_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                       clk,
    input  logic                       rstN,
    comm_parallel_master_if.master     bus
);

    localparam int CNT_W = $clog2(maxCyc(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    commState_t          state, nextState;
    logic                idx;
    logic                wrLatched;
    logic [NIBBLE_W-1:0] dataHi;
    logic                timerLoad;
    logic [CNT_W-1:0]    timerVal;
    logic                phaseDone;
    logic                accept;

    assign accept = (state == IDLE) && bus.reqValid && bus.reqReady;

    comm_phase_timer #(.CNT_W(CNT_W)) phaseTimer (
        .clk     (clk),
        .rstN    (rstN),
        .load    (timerLoad),
        .loadVal (timerVal),
        .done    (phaseDone)
    );

    always_comb begin
        nextState = state;
        timerLoad = 1'b0;
        timerVal  = '0;
        case (state)
            IDLE: if (accept) begin
                nextState = SETUP;
                timerLoad = 1'b1;
                timerVal  = SETUP_LD;
            end
            SETUP: if (phaseDone) begin
                nextState = STROBE;
                timerLoad = 1'b1;
                timerVal  = STROBE_LD;
            end
            STROBE: if (phaseDone) begin
                nextState = HOLD;
                timerLoad = 1'b1;
                timerVal  = HOLD_LD;
            end
            HOLD: if (phaseDone) begin
                if (!idx) begin
                    nextState = SETUP;
                    timerLoad = 1'b1;
                    timerVal  = SETUP_LD;
                end else begin
                    nextState = RESP;
                end
            end
            RESP: if (bus.rspReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Every handshake and strobe output is a flop fed from nextState, so it is glitch-free
    // and aligned with the state it belongs to.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= IDLE;
            idx            <= 1'b0;
            wrLatched      <= 1'b0;
            dataHi         <= '0;
            bus.reqReady   <= 1'b0;
            bus.rspValid   <= 1'b0;
            bus.rspData    <= '0;
            bus.busAddr    <= '0;
            bus.busDataOut <= '0;
            bus.busWrite   <= 1'b0;
            bus.busRead    <= 1'b0;
        end else begin
            state        <= nextState;
            bus.reqReady <= (nextState == IDLE);
            bus.rspValid <= (nextState == RESP);
            bus.busWrite <= (nextState == STROBE) && wrLatched;
            bus.busRead  <= (nextState == STROBE) && !wrLatched;

            if (accept) begin
                wrLatched      <= bus.reqWrite;
                idx            <= 1'b0;
                dataHi         <= bus.reqWrite ? bus.reqData[7:4] : '0;
                bus.busAddr    <= bus.reqAddr;
                bus.busDataOut <= bus.reqWrite ? bus.reqData[3:0] : '0;
                bus.rspData    <= '0;
            end

            if (state == STROBE && phaseDone && !wrLatched) begin
                if (idx) bus.rspData[7:4] <= bus.busDataIn;
                else     bus.rspData[3:0] <= bus.busDataIn;
            end

            // Address increment wraps naturally at ADDR_W bits.
            if (state == HOLD && phaseDone && !idx) begin
                idx            <= 1'b1;
                bus.busAddr    <= bus.busAddr + ADDR_W'(1);
                bus.busDataOut <= dataHi;
            end
        end
    end

endmodule
